icepic_seq: RTL

Fetch/execute sequencer for the iCEPIC baseline core. Owns the program counter and the 2-level hardware return stack, and drives the synchronous program ROM address. Presents each fetched word to `inst_dec` and consumes its control outputs (`pc_update_sel`, `jump_addr`, `stack_push`/`stack_pop`) plus the ALU skip result. Inserts a one-cycle bubble after every control-flow redirect so that GOTO, CALL, RETLW, taken skips and PCL writes take two cycles.

---
 rtl/icepic_lib_pkg.sv | 7 +
 rtl/icepic_stack.sv | 28 ++
 rtl/icepic_seq.sv | 79 +++++++
 3 files changed

// File: rtl/icepic_lib_pkg.sv
// icepic_lib_pkg: shared types and constants for the iCEPIC baseline core.
package icepic_lib_pkg;
    typedef enum logic [1:0] {PC_INC, PC_JUMP, PC_RETURN} pc_update_sel_t;
    typedef enum logic {ST_FETCH, ST_EXEC} seq_state_t;
    typedef logic [11:0] inst_t;
    localparam inst_t INST_NOP = 12'h000;
endpackage

// File: rtl/icepic_stack.sv
// icepic_stack: hardware return stack as a push/pop shift register.
// Overflow drops the oldest entry; underflow repeats the bottom entry.
module icepic_stack #(
    parameter int ADDR_WIDTH  = 9,
    parameter int STACK_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] din,
    output logic [ADDR_WIDTH-1:0] top
);
    logic [ADDR_WIDTH-1:0] mem [STACK_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            for (int i = STACK_DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
            mem[0] <= din;
        end else if (pop) begin
            for (int i = 0; i < STACK_DEPTH - 1; i++) mem[i] <= mem[i+1];
        end
    end

    assign top = mem[0];
endmodule

// File: rtl/icepic_seq.sv
// icepic_seq: fetch/execute sequencer owning the PC and return stack.
// Every redirect costs one bubble cycle in ST_FETCH.
module icepic_seq
    import icepic_lib_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 9,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = {ADDR_WIDTH{1'b1}},
    parameter int                    STACK_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hold_in,
    output logic [ADDR_WIDTH-1:0] prog_addr_out,
    input  logic [11:0]           prog_data_in,
    output inst_t                 inst_out,
    output logic                  inst_valid_out,
    input  logic [1:0]            page_in,
    input  pc_update_sel_t        pc_update_sel_in,
    input  logic [10:0]           jump_addr_in,
    input  logic                  stack_push_in,
    input  logic                  stack_pop_in,
    input  logic                  skip_in,
    input  logic                  pcl_write_in,
    input  logic [7:0]            pcl_data_in,
    input  logic                  f_write_en_in,
    input  logic                  w_write_en_in,
    output logic                  f_write_en_out,
    output logic                  w_write_en_out
);
    seq_state_t            state;
    logic [ADDR_WIDTH-1:0] pc, pc_next, stack_top;
    logic [10:0]           pcl_full;
    logic                  exec, do_ret, do_jump, do_pcl, do_skip, redirect, push, pop;
    logic                  unused;

    assign exec     = state == ST_EXEC;
    assign do_ret   = exec && pc_update_sel_in == PC_RETURN;
    assign do_jump  = exec && pc_update_sel_in == PC_JUMP;
    assign do_pcl   = exec && pcl_write_in;
    assign do_skip  = exec && skip_in;
    assign redirect = do_ret || do_jump || do_pcl || do_skip;
    assign pcl_full = {page_in, 1'b0, pcl_data_in};
    assign push     = !hold_in && do_jump && stack_push_in;
    assign pop      = !hold_in && do_ret;
    // stack_pop_in is redundant with PC_RETURN; upper address bits are truncated away
    assign unused   = ^{jump_addr_in, pcl_full, stack_pop_in};

    always_comb begin
        pc_next = do_ret  ? stack_top :
                  do_jump ? jump_addr_in[ADDR_WIDTH-1:0] :
                  do_pcl  ? pcl_full[ADDR_WIDTH-1:0] :
                            pc + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_VECTOR;
            state <= ST_FETCH;
        end else if (!hold_in) begin
            pc    <= pc_next;
            state <= redirect ? ST_FETCH : ST_EXEC;
        end
    end

    icepic_stack #(.ADDR_WIDTH(ADDR_WIDTH), .STACK_DEPTH(STACK_DEPTH)) u_stack (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .din  (pc),
        .top  (stack_top)
    );

    assign prog_addr_out  = pc;
    assign inst_valid_out = exec;
    assign inst_out       = exec ? prog_data_in : INST_NOP;
    assign f_write_en_out = f_write_en_in && exec && !hold_in;
    assign w_write_en_out = w_write_en_in && exec && !hold_in;
endmodule
